// File: rtl/goertzel_bin_scheduler_if.sv
// -----------------------------------------------------------------------------
// goertzel_bin_scheduler_if
//   Bundles the configuration bus, the Goertzel manager handshake (coefficient
//   request and magnitude pairs) and the tagged result stream of
//   goertzel_bin_scheduler.
//   Modports:
//     master : the side that drives configuration, request_trig and mag pairs
//              (host plus Goertzel manager)
//     slave  : goertzel_bin_scheduler itself
//   Signals (named from the scheduler's point of view):
//     cfg_we/cfg_addr/cfg_sin/cfg_cos   coefficient table write port
//     cfg_num_bins/cfg_commit           active bin count and schedule restart
//     request_trig -> trig_ready        coefficient request / valid strobe
//     sin_out/cos_out                   coefficients for the current bin
//     num_runs                          active_bins/2 for the manager
//     mag_rdy/mag_0/mag_1               magnitude pair from the manager
//     res_valid/res_bin/res_mag         serialised result stream
//     frame_done                        with the result of the last active bin
//     busy, err_overrun                 status
// -----------------------------------------------------------------------------
interface goertzel_bin_scheduler_if #(
   parameter int BIN_BITS = 5,
   parameter int COEFF_W  = 16
);
   logic                cfg_we;
   logic [BIN_BITS-1:0] cfg_addr;
   logic [COEFF_W-1:0]  cfg_sin;
   logic [COEFF_W-1:0]  cfg_cos;
   logic [BIN_BITS:0]   cfg_num_bins;
   logic                cfg_commit;
   logic                request_trig;
   logic                trig_ready;
   logic [COEFF_W-1:0]  sin_out;
   logic [COEFF_W-1:0]  cos_out;
   logic [4:0]          num_runs;
   logic                mag_rdy;
   logic [15:0]         mag_0;
   logic [15:0]         mag_1;
   logic                res_valid;
   logic [BIN_BITS-1:0] res_bin;
   logic [15:0]         res_mag;
   logic                frame_done;
   logic                busy;
   logic                err_overrun;

   modport master (
      output cfg_we, cfg_addr, cfg_sin, cfg_cos, cfg_num_bins, cfg_commit,
      output request_trig, mag_rdy, mag_0, mag_1,
      input  trig_ready, sin_out, cos_out, num_runs,
      input  res_valid, res_bin, res_mag, frame_done, busy, err_overrun
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_sin, cfg_cos, cfg_num_bins, cfg_commit,
      input  request_trig, mag_rdy, mag_0, mag_1,
      output trig_ready, sin_out, cos_out, num_runs,
      output res_valid, res_bin, res_mag, frame_done, busy, err_overrun
   );
endinterface

// File: rtl/goertzel_bin_scheduler.sv
// -----------------------------------------------------------------------------
// goertzel_bin_scheduler
//   Frequency-bin scheduler for the dual Goertzel manager. Holds a table of
//   per-bin sin/cos coefficients (fix 2.14, signed), answers the manager's
//   request_trig/trig_ready handshake in bin order, publishes num_runs and
//   serialises each magnitude pair into a tagged result stream with an
//   end-of-frame flag.
//   Ports:
//     sys_clk_i  system clock, all logic on the rising edge
//     rst_n_i    asynchronous active-low reset
//     bus_io     goertzel_bin_scheduler_if.slave (config, handshake, results)
// -----------------------------------------------------------------------------
module goertzel_bin_scheduler #(
   parameter int MAX_BINS = 32,   // even, <= 62
   parameter int BIN_BITS = 5,    // log2(MAX_BINS)
   parameter int COEFF_W  = 16
) (
   input  logic                    sys_clk_i,
   input  logic                    rst_n_i,
   goertzel_bin_scheduler_if.slave bus_io
);

   localparam int AB_W   = BIN_BITS + 1;
   localparam int RUNS_W = 5;
   localparam logic [AB_W-1:0] MAX_BINS_C = AB_W'(MAX_BINS);

   typedef enum logic [1:0] {T_IDLE, T_READ, T_PRESENT} trig_state_e;
   typedef enum logic [1:0] {R_IDLE, R_EMIT0, R_EMIT1}  res_state_e;

   // ---------------------------------------------------------------- commit
   logic                commit;
   logic [AB_W-1:0]     even_req;
   logic [AB_W-1:0]     commit_bins;
   logic [AB_W-1:0]     active_bins_q, active_bins_d;
   logic [RUNS_W-1:0]   num_runs_q, num_runs_d;

   assign commit   = bus_io.cfg_commit;
   // Odd requests round down: bins are always processed in pairs.
   assign even_req    = {bus_io.cfg_num_bins[AB_W-1:1], 1'b0};
   assign commit_bins = (even_req > MAX_BINS_C) ? MAX_BINS_C : even_req;

   always_comb begin
      active_bins_d = active_bins_q;
      num_runs_d    = num_runs_q;
      if (commit) begin
         active_bins_d = commit_bins;
         num_runs_d    = RUNS_W'(commit_bins >> 1);
      end
   end

   // ------------------------------------------------------ coefficient table
   // Two lanes (0 = cos, 1 = sin), each an inferred RAM with a registered
   // read. The read register samples the array before this edge's write,
   // so a same-slot write/read returns the old coefficient.
   logic                rd_en;
   logic                wr_en;
   logic [BIN_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [COEFF_W-1:0]  wr_lane [2];
   logic [COEFF_W-1:0]  rd_lane [2];

   assign wr_en      = bus_io.cfg_we && ({1'b0, bus_io.cfg_addr} < MAX_BINS_C);
   assign wr_lane[0] = bus_io.cfg_cos;
   assign wr_lane[1] = bus_io.cfg_sin;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [COEFF_W-1:0] mem [MAX_BINS];
         logic [COEFF_W-1:0] rd_data_q;

         always_ff @(posedge sys_clk_i) begin
            if (wr_en) begin
               mem[bus_io.cfg_addr] <= wr_lane[gi];
            end
            if (rd_en) begin
               rd_data_q <= mem[rd_ptr_q];
            end
         end

         assign rd_lane[gi] = rd_data_q;
      end
   endgenerate

   // -------------------------------------------------------------- trig FSM
   trig_state_e         trig_state_q, trig_state_d;
   logic [COEFF_W-1:0]  sin_q, sin_d;
   logic [COEFF_W-1:0]  cos_q, cos_d;
   logic                trig_ready_q, trig_ready_d;
   logic [AB_W-1:0]     rd_ptr_inc;

   assign rd_ptr_inc = {1'b0, rd_ptr_q} + AB_W'(1);

   always_comb begin
      trig_state_d = trig_state_q;
      rd_ptr_d     = rd_ptr_q;
      sin_d        = sin_q;
      cos_d        = cos_q;
      trig_ready_d = 1'b0;
      rd_en        = 1'b0;
      if (commit) begin
         // Commit wins over everything, including a strobe due this cycle.
         trig_state_d = T_IDLE;
         rd_ptr_d     = '0;
      end else begin
         unique case (trig_state_q)
            T_IDLE: begin
               if (bus_io.request_trig && (active_bins_q != '0)) begin
                  rd_en        = 1'b1;
                  trig_state_d = T_READ;
               end
            end
            T_READ: begin
               // RAM output register is loaded; one more cycle to present it.
               trig_state_d = T_PRESENT;
            end
            T_PRESENT: begin
               sin_d        = rd_lane[1];
               cos_d        = rd_lane[0];
               trig_ready_d = 1'b1;
               rd_ptr_d     = (rd_ptr_inc == active_bins_q) ? '0 : rd_ptr_inc[BIN_BITS-1:0];
               trig_state_d = T_IDLE;
            end
            default: trig_state_d = T_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ result FSM
   // Result outputs are registered from the next-state decode so that they
   // are valid during the EMIT state they belong to and hold while idle.
   res_state_e          res_state_q, res_state_d;
   logic [BIN_BITS-1:0] res_ptr_q, res_ptr_d;
   logic [15:0]         mag0_q, mag0_d;
   logic [15:0]         mag1_q, mag1_d;
   logic                res_valid_q, res_valid_d;
   logic [BIN_BITS-1:0] res_bin_q, res_bin_d;
   logic [15:0]         res_mag_q, res_mag_d;
   logic                frame_done_q, frame_done_d;
   logic                err_q, err_d;
   logic [AB_W-1:0]     res_ptr_inc2;

   assign res_ptr_inc2 = {1'b0, res_ptr_q} + AB_W'(2);

   always_comb begin
      res_state_d  = res_state_q;
      res_ptr_d    = res_ptr_q;
      mag0_d       = mag0_q;
      mag1_d       = mag1_q;
      err_d        = err_q;
      res_valid_d  = 1'b0;
      res_bin_d    = res_bin_q;
      res_mag_d    = res_mag_q;
      frame_done_d = 1'b0;
      if (commit) begin
         res_state_d = R_IDLE;
         res_ptr_d   = '0;
         err_d       = 1'b0;
      end else if (bus_io.mag_rdy) begin
         // A pair arriving mid-emission replaces the captured one and
         // restarts at the same res_ptr; the lost pair is flagged.
         if (res_state_q != R_IDLE) begin
            err_d = 1'b1;
         end
         mag0_d      = bus_io.mag_0;
         mag1_d      = bus_io.mag_1;
         res_state_d = R_EMIT0;
         res_valid_d = 1'b1;
         res_bin_d   = res_ptr_q;
         res_mag_d   = bus_io.mag_0;
      end else begin
         unique case (res_state_q)
            R_EMIT0: begin
               res_state_d  = R_EMIT1;
               res_valid_d  = 1'b1;
               res_bin_d    = res_ptr_q + BIN_BITS'(1);
               res_mag_d    = mag1_q;
               frame_done_d = (res_ptr_inc2 == active_bins_q);
            end
            R_EMIT1: begin
               res_state_d = R_IDLE;
               res_ptr_d   = (res_ptr_inc2 == active_bins_q) ? '0 : res_ptr_inc2[BIN_BITS-1:0];
            end
            default: res_state_d = R_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         active_bins_q <= '0;
         num_runs_q    <= '0;
         trig_state_q  <= T_IDLE;
         rd_ptr_q      <= '0;
         sin_q         <= '0;
         cos_q         <= '0;
         trig_ready_q  <= 1'b0;
         res_state_q   <= R_IDLE;
         res_ptr_q     <= '0;
         mag0_q        <= '0;
         mag1_q        <= '0;
         res_valid_q   <= 1'b0;
         res_bin_q     <= '0;
         res_mag_q     <= '0;
         frame_done_q  <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         active_bins_q <= active_bins_d;
         num_runs_q    <= num_runs_d;
         trig_state_q  <= trig_state_d;
         rd_ptr_q      <= rd_ptr_d;
         sin_q         <= sin_d;
         cos_q         <= cos_d;
         trig_ready_q  <= trig_ready_d;
         res_state_q   <= res_state_d;
         res_ptr_q     <= res_ptr_d;
         mag0_q        <= mag0_d;
         mag1_q        <= mag1_d;
         res_valid_q   <= res_valid_d;
         res_bin_q     <= res_bin_d;
         res_mag_q     <= res_mag_d;
         frame_done_q  <= frame_done_d;
         err_q         <= err_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus_io.trig_ready  = trig_ready_q;
   assign bus_io.sin_out     = sin_q;
   assign bus_io.cos_out     = cos_q;
   assign bus_io.num_runs    = num_runs_q;
   assign bus_io.res_valid   = res_valid_q;
   assign bus_io.res_bin     = res_bin_q;
   assign bus_io.res_mag     = res_mag_q;
   assign bus_io.frame_done  = frame_done_q;
   assign bus_io.err_overrun = err_q;
   assign bus_io.busy        = (rd_ptr_q != '0) || (res_ptr_q != '0) ||
                               (trig_state_q != T_IDLE) || (res_state_q != R_IDLE);

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// -----------------------------------------------------------------------------
// tb_goertzel_bin_scheduler
//   Scoreboard bench: request/mag stimulus pushes expected coefficient strobes
//   and result beats; negedge monitors pop and compare them. Scenario tasks
//   check status outputs inline.
// -----------------------------------------------------------------------------
module tb_goertzel_bin_scheduler;
   localparam int MAX_BINS = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   goertzel_bin_scheduler_if #(.BIN_BITS(5), .COEFF_W(16)) bus ();

   goertzel_bin_scheduler #(.MAX_BINS(MAX_BINS), .BIN_BITS(5), .COEFF_W(16)) dut (
      .sys_clk_i (clk),
      .rst_n_i   (rst_n),
      .bus_io    (bus)
   );

   typedef struct {
      logic [15:0] s;
      logic [15:0] c;
      int          cyc;
   } trig_exp_t;

   typedef struct {
      logic [4:0]  bin;
      logic [15:0] mag;
      logic        fd;
   } res_exp_t;

   trig_exp_t trig_q[$];
   res_exp_t  res_q[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int trig_seen = 0;

   logic [15:0] m_sin [MAX_BINS];
   logic [15:0] m_cos [MAX_BINS];
   int m_active = 0;
   int m_rd_ptr = 0;
   int m_res_ptr = 0;

   always @(posedge clk) cyc++;

   // ------------------------------------------------------------- monitors
   trig_exp_t te;
   res_exp_t  re;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.trig_ready) begin
            trig_seen++;
            total++;
            if (trig_q.size() == 0) begin
               bad++;
               $display("FAIL trig_unexpected got sin=%h cos=%h required no strobe", bus.sin_out, bus.cos_out);
            end else begin
               te = trig_q.pop_front();
               if (bus.sin_out !== te.s || bus.cos_out !== te.c || cyc !== te.cyc) begin
                  bad++;
                  $display("FAIL trig_data got sin=%h cos=%h cyc=%0d required sin=%h cos=%h cyc=%0d",
                           bus.sin_out, bus.cos_out, cyc, te.s, te.c, te.cyc);
               end else begin
                  $display("trig sin=%h cos=%h cyc=%0d ok", bus.sin_out, bus.cos_out, cyc);
               end
            end
         end
         if (bus.res_valid) begin
            total++;
            if (res_q.size() == 0) begin
               bad++;
               $display("FAIL res_unexpected got bin=%0d mag=%h required no result", bus.res_bin, bus.res_mag);
            end else begin
               re = res_q.pop_front();
               if (bus.res_bin !== re.bin || bus.res_mag !== re.mag || bus.frame_done !== re.fd) begin
                  bad++;
                  $display("FAIL res_data got bin=%0d mag=%h fd=%b required bin=%0d mag=%h fd=%b",
                           bus.res_bin, bus.res_mag, bus.frame_done, re.bin, re.mag, re.fd);
               end else begin
                  $display("res bin=%0d mag=%h fd=%b ok", bus.res_bin, bus.res_mag, bus.frame_done);
               end
            end
         end else if (bus.frame_done) begin
            total++;
            bad++;
            $display("FAIL frame_done_alone got frame_done=1 required 0 without res_valid");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- tasks
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_coeff(input int k, input logic [15:0] s, input logic [15:0] c);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 5'(k);
      bus.cfg_sin  = s;
      bus.cfg_cos  = c;
      tick();
      bus.cfg_we   = 1'b0;
      m_sin[k] = s;
      m_cos[k] = c;
   endtask

   task automatic do_commit(input int n);
      bus.cfg_num_bins = 6'(n);
      bus.cfg_commit   = 1'b1;
      tick();
      bus.cfg_commit   = 1'b0;
      m_active  = n & ~1;
      if (m_active > MAX_BINS) m_active = MAX_BINS;
      m_rd_ptr  = 0;
      m_res_ptr = 0;
   endtask

   task automatic push_trig();
      trig_exp_t e;
      if (m_active != 0) begin
         e.s   = m_sin[m_rd_ptr];
         e.c   = m_cos[m_rd_ptr];
         e.cyc = cyc + 3;
         trig_q.push_back(e);
         m_rd_ptr = (m_rd_ptr + 1 == m_active) ? 0 : m_rd_ptr + 1;
      end
   endtask

   task automatic request();
      push_trig();
      bus.request_trig = 1'b1;
      tick();
      bus.request_trig = 1'b0;
      tick(3);
   endtask

   task automatic push_pair(input logic [15:0] m0, input logic [15:0] m1);
      res_exp_t e;
      e.bin = 5'(m_res_ptr);     e.mag = m0; e.fd = 1'b0;
      res_q.push_back(e);
      e.bin = 5'(m_res_ptr + 1); e.mag = m1; e.fd = (m_res_ptr + 2 == m_active);
      res_q.push_back(e);
      m_res_ptr = (m_res_ptr + 2 == m_active) ? 0 : m_res_ptr + 2;
   endtask

   task automatic mag_pair(input logic [15:0] m0, input logic [15:0] m1);
      push_pair(m0, m1);
      bus.mag_rdy = 1'b1;
      bus.mag_0   = m0;
      bus.mag_1   = m1;
      tick();
      bus.mag_rdy = 1'b0;
      tick(3);
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (trig_q.size() == 0 && res_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick(2);
   endtask

   // ------------------------------------------------------------ scenarios
   task automatic test_reset();
      bit ok;
      tick(2);
      total++;
      if ({bus.trig_ready, bus.res_valid, bus.frame_done, bus.busy, bus.err_overrun} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags got %b required 00000",
                  {bus.trig_ready, bus.res_valid, bus.frame_done, bus.busy, bus.err_overrun});
      end
      total++;
      if ({bus.sin_out, bus.cos_out, bus.res_mag, bus.res_bin, bus.num_runs} !== 58'b0) begin
         bad++;
         $display("FAIL reset_data got sin=%h cos=%h mag=%h bin=%0d runs=%0d required all 0",
                  bus.sin_out, bus.cos_out, bus.res_mag, bus.res_bin, bus.num_runs);
      end
      rst_n = 1'b1;
      tick();
      request();
      wait_drain(ok);
      total++;
      if (trig_seen !== 0) begin
         bad++;
         $display("FAIL reset_req_ignored got strobes=%0d required 0", trig_seen);
      end
      $display("test_reset done");
   endtask

   task automatic test_trig_order();
      bit ok;
      int seen0;
      for (int k = 0; k < 4; k++) write_coeff(k, 16'(16'h0100 * k), 16'(16'h4000 - k));
      do_commit(4);
      total++;
      if (bus.num_runs !== 5'd2) begin
         bad++;
         $display("FAIL t1_num_runs got %0d required 2", bus.num_runs);
      end
      seen0 = trig_seen;
      for (int k = 0; k < 4; k++) request();
      wait_drain(ok);
      total++;
      if (ok !== 1'b1 || trig_seen - seen0 !== 4) begin
         bad++;
         $display("FAIL t1_strobes got %0d pending=%0d required 4 pending=0", trig_seen - seen0, trig_q.size());
         trig_q.delete();
      end
      $display("test_trig_order done");
   endtask

   task automatic test_rd_wrap();
      bit ok;
      request();
      wait_drain(ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL t2_drain got pending=%0d required 0", trig_q.size());
         trig_q.delete();
      end
      total++;
      if (bus.sin_out !== 16'h0000 || bus.cos_out !== 16'h4000) begin
         bad++;
         $display("FAIL t2_hold got sin=%h cos=%h required sin=0000 cos=4000", bus.sin_out, bus.cos_out);
      end
      $display("test_rd_wrap done");
   endtask

   task automatic test_results();
      bit ok;
      do_commit(4);
      mag_pair(16'h1111, 16'h2222);
      mag_pair(16'h3333, 16'h4444);
      wait_drain(ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL t3_drain got pending=%0d required 0", res_q.size());
         res_q.delete();
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL t3_busy got %b required 0", bus.busy);
      end
      $display("test_results done");
   endtask

   task automatic test_commit_sizes();
      int seen0;
      do_commit(7);
      total++;
      if (bus.num_runs !== 5'd3) begin
         bad++;
         $display("FAIL t4_runs7 got %0d required 3", bus.num_runs);
      end
      do_commit(40);
      total++;
      if (bus.num_runs !== 5'd16) begin
         bad++;
         $display("FAIL t4_runs40 got %0d required 16", bus.num_runs);
      end
      do_commit(63);
      total++;
      if (bus.num_runs !== 5'd16) begin
         bad++;
         $display("FAIL t4_runs63 got %0d required 16", bus.num_runs);
      end
      do_commit(0);
      total++;
      if (bus.num_runs !== 5'd0) begin
         bad++;
         $display("FAIL t4_runs0 got %0d required 0", bus.num_runs);
      end
      seen0 = trig_seen;
      request();
      request();
      tick(3);
      total++;
      if (trig_seen !== seen0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL t4_zero_bins got strobes=%0d busy=%b required 0 strobes busy=0",
                  trig_seen - seen0, bus.busy);
      end
      $display("test_commit_sizes done");
   endtask

   task automatic test_overrun();
      bit ok;
      res_exp_t e;
      do_commit(4);
      total++;
      if (bus.err_overrun !== 1'b0) begin
         bad++;
         $display("FAIL t5_err_pre got %b required 0", bus.err_overrun);
      end
      // First pair is cut short after its even beat; second pair restarts at bin 0.
      e.bin = 5'd0; e.mag = 16'hA0A0; e.fd = 1'b0; res_q.push_back(e);
      e.bin = 5'd0; e.mag = 16'hB0B0; e.fd = 1'b0; res_q.push_back(e);
      e.bin = 5'd1; e.mag = 16'hB1B1; e.fd = 1'b0; res_q.push_back(e);
      bus.mag_rdy = 1'b1;
      bus.mag_0 = 16'hA0A0;
      bus.mag_1 = 16'hA1A1;
      tick();
      bus.mag_0 = 16'hB0B0;
      bus.mag_1 = 16'hB1B1;
      tick();
      bus.mag_rdy = 1'b0;
      wait_drain(ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL t5_drain got pending=%0d required 0", res_q.size());
         res_q.delete();
      end
      total++;
      if (bus.err_overrun !== 1'b1) begin
         bad++;
         $display("FAIL t5_err_set got %b required 1", bus.err_overrun);
      end
      do_commit(4);
      total++;
      if (bus.err_overrun !== 1'b0) begin
         bad++;
         $display("FAIL t5_err_clear got %b required 0", bus.err_overrun);
      end
      $display("test_overrun done");
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_commit(4);
      // Request, same-slot write and magnitude pair all in one cycle.
      push_trig();
      push_pair(16'h5555, 16'h6666);
      bus.request_trig = 1'b1;
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 5'd0;
      bus.cfg_sin  = 16'h7777;
      bus.cfg_cos  = 16'h1234;
      bus.mag_rdy  = 1'b1;
      bus.mag_0    = 16'h5555;
      bus.mag_1    = 16'h6666;
      tick();
      bus.request_trig = 1'b0;
      bus.cfg_we  = 1'b0;
      bus.mag_rdy = 1'b0;
      m_sin[0] = 16'h7777;
      m_cos[0] = 16'h1234;
      tick(3);
      wait_drain(ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL b2b_drain got trig=%0d res=%0d required 0", trig_q.size(), res_q.size());
         trig_q.delete();
         res_q.delete();
      end
      do_commit(4);
      request();
      wait_drain(ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL b2b_newdata got pending=%0d required 0", trig_q.size());
         trig_q.delete();
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int seen0;
      do_commit(4);
      for (int k = 0; k < 3; k++) request();
      wait_drain(ok);
      total++;
      if (ok !== 1'b1 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL t6_pre got busy=%b pending=%0d required busy=1 pending=0", bus.busy, trig_q.size());
         trig_q.delete();
      end
      push_pair(16'hAAAA, 16'hBBBB);
      bus.mag_rdy = 1'b1;
      bus.mag_0 = 16'hAAAA;
      bus.mag_1 = 16'hBBBB;
      tick();
      bus.mag_rdy = 1'b0;
      tick();
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_bin !== 5'd1) begin
         bad++;
         $display("FAIL t6_emit1 got valid=%b bin=%0d required valid=1 bin=1", bus.res_valid, bus.res_bin);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.trig_ready, bus.res_valid, bus.frame_done, bus.busy, bus.err_overrun} !== 5'b0) begin
         bad++;
         $display("FAIL t6_rst_flags got %b required 00000",
                  {bus.trig_ready, bus.res_valid, bus.frame_done, bus.busy, bus.err_overrun});
      end
      total++;
      if (bus.sin_out !== 16'h0 || bus.cos_out !== 16'h0 || bus.num_runs !== 5'd0) begin
         bad++;
         $display("FAIL t6_rst_coeff got sin=%h cos=%h runs=%0d required 0", bus.sin_out, bus.cos_out, bus.num_runs);
      end
      total++;
      if (bus.res_bin !== 5'd0 || bus.res_mag !== 16'h0) begin
         bad++;
         $display("FAIL t6_rst_res got bin=%0d mag=%h required 0", bus.res_bin, bus.res_mag);
      end
      res_q.delete();
      trig_q.delete();
      m_active = 0;
      m_rd_ptr = 0;
      m_res_ptr = 0;
      tick(2);
      rst_n = 1'b1;
      tick();
      seen0 = trig_seen;
      request();
      tick(3);
      total++;
      if (trig_seen !== seen0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL t6_post_req got strobes=%0d busy=%b required 0 strobes busy=0",
                  trig_seen - seen0, bus.busy);
      end
      $display("test_reset_mid_frame done");
   endtask

   initial begin
      bus.cfg_we       = 1'b0;
      bus.cfg_addr     = '0;
      bus.cfg_sin      = '0;
      bus.cfg_cos      = '0;
      bus.cfg_num_bins = '0;
      bus.cfg_commit   = 1'b0;
      bus.request_trig = 1'b0;
      bus.mag_rdy      = 1'b0;
      bus.mag_0        = '0;
      bus.mag_1        = '0;
      for (int k = 0; k < MAX_BINS; k++) begin
         m_sin[k] = 'x;
         m_cos[k] = 'x;
      end

      test_reset();
      test_trig_order();
      test_rd_wrap();
      test_results();
      test_commit_sizes();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
